bcd_alarm_clock: RTL and testbench

Parametrised BCD real-time clock with 12/24-hour mode and ALARM_CNT independent alarm channels. It has a programmable prescaler and a validated time-set path. It is the next-generation timekeeping core driving the six-digit display and alarm LEDs. Each alarm channel has its own ring timeout and acknowledge.

---
 rtl/bcd_alarm_clock.sv | 223 ++++++++++++++++++++++
 tb/tb_bcd_alarm_clock.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alarm_clock.sv
// BCD real-time clock (12/24 h) with ALARM_CNT independently armed alarm channels.
// Build with SNOOZE_EN defined to add per-channel snooze counters.
module bcd_alarm_clock #(
  parameter int CLK_DIV    = 1,
  parameter int HOUR_24    = 1,
  parameter int ALARM_CNT  = 2,
  parameter int ALARM_LEN  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [19:0]          set_time,
  input  logic                 set_pm,
  input  logic                 alarm_wr,
  input  logic [2:0]           alarm_idx,
  input  logic [12:0]          alarm_time,
  input  logic                 alarm_pm,
  input  logic [ALARM_CNT-1:0] alarm_arm,
  input  logic [ALARM_CNT-1:0] alarm_ack,
  input  logic [ALARM_CNT-1:0] snooze,
  output logic [1:0]           H1,
  output logic [3:0]           H2,
  output logic [2:0]           M1,
  output logic [3:0]           M2,
  output logic [2:0]           S1,
  output logic [3:0]           S2,
  output logic                 pm,
  output logic                 tick,
  output logic                 set_err,
  output logic [ALARM_CNT-1:0] alarm_ring,
  output logic                 led_alarm
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [1:0] H1_RST = (HOUR_24 != 0) ? 2'd0 : 2'd1;
  localparam logic [3:0] H2_RST = (HOUR_24 != 0) ? 4'd0 : 4'd2;
  localparam logic [12:0] ALM_RST = {H1_RST, H2_RST, 3'd0, 4'd0};

  function automatic logic hm_legal(input logic [1:0] h1, input logic [3:0] h2,
                                    input logic [2:0] m1, input logic [3:0] m2);
    logic ok;
    ok = (h2 <= 4'd9) && (m1 <= 3'd5) && (m2 <= 4'd9);
    if (HOUR_24 != 0)
      ok = ok && ((h1 < 2'd2) || ((h1 == 2'd2) && (h2 <= 4'd3)));
    else
      ok = ok && (((h1 == 2'd0) && (h2 != 4'd0)) || ((h1 == 2'd1) && (h2 <= 4'd2)));
    return ok;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] h1_q, h1_d, h1_inc;
  logic [3:0] h2_q, h2_d, h2_inc;
  logic [2:0] m1_q, m1_d, m1_inc;
  logic [3:0] m2_q, m2_d, m2_inc;
  logic [2:0] s1_q, s1_d, s1_inc;
  logic [3:0] s2_q, s2_d, s2_inc;
  logic       pm_q, pm_d, pm_inc;
  logic       set_err_q, set_err_d;
  logic       set_legal, set_ok, alarm_ok, inc_top;
  logic       unused_ok;

  assign set_legal = hm_legal(set_time[19:18], set_time[17:14], set_time[13:11], set_time[10:7])
                     && (set_time[6:4] <= 3'd5) && (set_time[3:0] <= 4'd9);
  assign set_ok    = set_valid && set_legal;
  assign alarm_ok  = alarm_wr && (32'(alarm_idx) < ALARM_CNT)
                     && hm_legal(alarm_time[12:11], alarm_time[10:7], alarm_time[6:4], alarm_time[3:0]);
  assign tick      = (presc_q == PRESC_MAX);
  assign unused_ok = ^{snooze, set_pm, alarm_pm, (SNOOZE_MIN > 0)};

  always_comb begin
    h1_inc = h1_q; h2_inc = h2_q; m1_inc = m1_q; m2_inc = m2_q;
    s1_inc = s1_q; s2_inc = s2_q; pm_inc = pm_q;
    if (s2_q != 4'd9) s2_inc = s2_q + 4'd1;
    else begin
      s2_inc = '0;
      if (s1_q != 3'd5) s1_inc = s1_q + 3'd1;
      else begin
        s1_inc = '0;
        if (m2_q != 4'd9) m2_inc = m2_q + 4'd1;
        else begin
          m2_inc = '0;
          if (m1_q != 3'd5) m1_inc = m1_q + 3'd1;
          else begin
            m1_inc = '0;
            if (HOUR_24 != 0) begin
              if (h1_q == 2'd2 && h2_q == 4'd3) begin h1_inc = '0; h2_inc = '0; end
              else if (h2_q == 4'd9) begin h1_inc = h1_q + 2'd1; h2_inc = '0; end
              else h2_inc = h2_q + 4'd1;
            end else begin
              // 12 rolls to 01 without touching pm; 11 rolls to 12 and flips it
              if (h1_q == 2'd1 && h2_q == 4'd2) begin h1_inc = 2'd0; h2_inc = 4'd1; end
              else if (h1_q == 2'd1 && h2_q == 4'd1) begin h2_inc = 4'd2; pm_inc = ~pm_q; end
              else if (h2_q == 4'd9) begin h1_inc = 2'd1; h2_inc = '0; end
              else h2_inc = h2_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    h1_d = h1_q; h2_d = h2_q; m1_d = m1_q; m2_d = m2_q;
    s1_d = s1_q; s2_d = s2_q; pm_d = pm_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    set_err_d = (set_valid && !set_legal) || (alarm_wr && !alarm_ok);
    if (set_ok) begin
      h1_d = set_time[19:18]; h2_d = set_time[17:14];
      m1_d = set_time[13:11]; m2_d = set_time[10:7];
      s1_d = set_time[6:4];   s2_d = set_time[3:0];
      pm_d = (HOUR_24 != 0) ? 1'b0 : set_pm;
      presc_d = '0;
    end else if (tick) begin
      h1_d = h1_inc; h2_d = h2_inc; m1_d = m1_inc; m2_d = m2_inc;
      s1_d = s1_inc; s2_d = s2_inc; pm_d = pm_inc;
    end
  end

  // Only a counted minute rollover can fire an alarm, never a time load.
  assign inc_top = tick && !set_ok && (s1_inc == 3'd0) && (s2_inc == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      h1_q <= H1_RST; h2_q <= H2_RST; m1_q <= '0; m2_q <= '0;
      s1_q <= '0; s2_q <= '0; pm_q <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      h1_q <= h1_d; h2_q <= h2_d; m1_q <= m1_d; m2_q <= m2_d;
      s1_q <= s1_d; s2_q <= s2_d; pm_q <= pm_d;
      set_err_q <= set_err_d;
    end
  end

  for (genvar gi = 0; gi < ALARM_CNT; gi++) begin : ch
    logic [12:0]   alm_q, alm_d;
    logic          alm_pm_q, alm_pm_d;
    logic          ring_q, ring_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          match;
`ifdef SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
    logic          snz_q, snz_d;
    logic [SW-1:0] scnt_q, scnt_d;
`endif

    assign match = inc_top && alarm_arm[gi]
                   && ({h1_inc, h2_inc, m1_inc, m2_inc} == alm_q)
                   && ((HOUR_24 != 0) || (pm_inc == alm_pm_q));

    always_comb begin
      alm_d = alm_q; alm_pm_d = alm_pm_q;
      ring_d = ring_q; rcnt_d = rcnt_q;
`ifdef SNOOZE_EN
      snz_d = snz_q; scnt_d = scnt_q;
`endif
      if (alarm_ok && (alarm_idx == 3'(gi))) begin
        alm_d = alarm_time;
        alm_pm_d = (HOUR_24 != 0) ? 1'b0 : alarm_pm;
      end
      if (alarm_ack[gi] || !alarm_arm[gi]) begin
        ring_d = 1'b0; rcnt_d = '0;
`ifdef SNOOZE_EN
        snz_d = 1'b0; scnt_d = '0;
`endif
      end else if (match) begin
        ring_d = 1'b1; rcnt_d = RW'(ALARM_LEN);
`ifdef SNOOZE_EN
        snz_d = 1'b0; scnt_d = '0;
`endif
      end
`ifdef SNOOZE_EN
      else if (snooze[gi] && ring_q) begin
        ring_d = 1'b0; rcnt_d = '0;
        snz_d = 1'b1; scnt_d = SW'(SNOOZE_MIN * 60);
      end
`endif
      else if (tick) begin
        if (ring_q) begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q == RW'(1)) ring_d = 1'b0;
        end
`ifdef SNOOZE_EN
        if (snz_q) begin
          scnt_d = scnt_q - 1'b1;
          if (scnt_q == SW'(1)) begin
            snz_d = 1'b0; ring_d = 1'b1; rcnt_d = RW'(ALARM_LEN);
          end
        end
`endif
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        alm_q <= ALM_RST; alm_pm_q <= 1'b0;
        ring_q <= 1'b0; rcnt_q <= '0;
`ifdef SNOOZE_EN
        snz_q <= 1'b0; scnt_q <= '0;
`endif
      end else begin
        alm_q <= alm_d; alm_pm_q <= alm_pm_d;
        ring_q <= ring_d; rcnt_q <= rcnt_d;
`ifdef SNOOZE_EN
        snz_q <= snz_d; scnt_q <= scnt_d;
`endif
      end
    end

    assign alarm_ring[gi] = ring_q;
  end

  assign H1 = h1_q; assign H2 = h2_q; assign M1 = m1_q;
  assign M2 = m2_q; assign S1 = s1_q; assign S2 = s2_q;
  assign pm        = pm_q;
  assign set_err   = set_err_q;
  assign led_alarm = |alarm_ring;

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Bench: a 24 h and a 12 h instance share stimulus; a seconds-of-day model checks both.
module tb_bcd_alarm_clock;
  localparam int CD = 4, AC = 2, AL = 60, SM = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, set_valid, set_pm, alarm_wr, alarm_pm;
  logic [19:0] set_time;
  logic [2:0]  alarm_idx;
  logic [12:0] alarm_time;
  logic [1:0]  alarm_arm, alarm_ack, snooze;

  logic [1:0] o_h1 [2];
  logic [3:0] o_h2 [2];
  logic [2:0] o_m1 [2];
  logic [3:0] o_m2 [2];
  logic [2:0] o_s1 [2];
  logic [3:0] o_s2 [2];
  logic       o_pm [2];
  logic       o_tick [2];
  logic       o_err [2];
  logic [1:0] o_ring [2];
  logic       o_led [2];

  bcd_alarm_clock #(.CLK_DIV(CD), .HOUR_24(1), .ALARM_CNT(AC), .ALARM_LEN(AL), .SNOOZE_MIN(SM)) u24 (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_time(set_time), .set_pm(set_pm),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .snooze(snooze),
    .H1(o_h1[0]), .H2(o_h2[0]), .M1(o_m1[0]), .M2(o_m2[0]), .S1(o_s1[0]), .S2(o_s2[0]),
    .pm(o_pm[0]), .tick(o_tick[0]), .set_err(o_err[0]), .alarm_ring(o_ring[0]), .led_alarm(o_led[0]));

  bcd_alarm_clock #(.CLK_DIV(CD), .HOUR_24(0), .ALARM_CNT(AC), .ALARM_LEN(AL), .SNOOZE_MIN(SM)) u12 (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_time(set_time), .set_pm(set_pm),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_time(alarm_time), .alarm_pm(alarm_pm),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .snooze(snooze),
    .H1(o_h1[1]), .H2(o_h2[1]), .M1(o_m1[1]), .M2(o_m2[1]), .S1(o_s1[1]), .S2(o_s2[1]),
    .pm(o_pm[1]), .tick(o_tick[1]), .set_err(o_err[1]), .alarm_ring(o_ring[1]), .led_alarm(o_led[1]));

  // Reference model, index 0 = 24 h instance, 1 = 12 h instance.
  int tod [2];
  int presc [2];
  int amin [2][2];
  bit mring [2][2];
  int rleft [2][2];
  bit msnz [2][2];
  int sleft [2][2];
  bit merr [2];
  int checks = 0, errors = 0;

  typedef struct {
    logic [19:0] t;
    bit          p;
    bit          e24;
    bit          e12;
  } set_vec_t;
  set_vec_t tv [9];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] bcd6(int a, int b, int c, int d, int e, int f);
    return {2'(a), 4'(b), 3'(c), 4'(d), 3'(e), 4'(f)};
  endfunction

  function automatic bit hm_ok(int mode, int h1, int h2, int m1, int m2);
    int hh, mm;
    if (h2 > 9 || m2 > 9) return 0;
    hh = h1 * 10 + h2;
    mm = m1 * 10 + m2;
    if (mm > 59) return 0;
    return (mode == 0) ? (hh <= 23) : (hh >= 1 && hh <= 12);
  endfunction

  function automatic int to_min(int mode, int hh, int mm, bit p);
    return (mode == 0) ? hh * 60 + mm : ((hh % 12) + (p ? 12 : 0)) * 60 + mm;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      tod[m] = 0; presc[m] = 0; merr[m] = 0;
      for (int i = 0; i < AC; i++) begin
        amin[m][i] = 0; mring[m][i] = 0; rleft[m][i] = 0; msnz[m][i] = 0; sleft[m][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit tk, sok, aok, inc, match;
      int nt;
      tk  = (presc[m] == CD - 1);
      sok = set_valid && hm_ok(m, set_time[19:18], set_time[17:14], set_time[13:11], set_time[10:7])
            && set_time[6:4] <= 5 && set_time[3:0] <= 9;
      aok = alarm_wr && alarm_idx < AC
            && hm_ok(m, alarm_time[12:11], alarm_time[10:7], alarm_time[6:4], alarm_time[3:0]);
      merr[m] = (set_valid && !sok) || (alarm_wr && !aok);
      nt = tod[m];
      inc = 0;
      if (sok) begin
        nt = to_min(m, set_time[19:18] * 10 + set_time[17:14], set_time[13:11] * 10 + set_time[10:7], set_pm) * 60
             + set_time[6:4] * 10 + set_time[3:0];
        presc[m] = 0;
      end else begin
        presc[m] = tk ? 0 : presc[m] + 1;
        if (tk) begin nt = (tod[m] + 1) % 86400; inc = 1; end
      end
      for (int i = 0; i < AC; i++) begin
        match = inc && (nt % 60 == 0) && (nt / 60 == amin[m][i]) && alarm_arm[i];
        if (alarm_ack[i] || !alarm_arm[i]) begin
          mring[m][i] = 0; msnz[m][i] = 0;
        end else if (match) begin
          mring[m][i] = 1; rleft[m][i] = AL; msnz[m][i] = 0;
        end
`ifdef SNOOZE_EN
        else if (snooze[i] && mring[m][i]) begin
          mring[m][i] = 0; msnz[m][i] = 1; sleft[m][i] = SM * 60;
        end
`endif
        else if (tk) begin
          if (mring[m][i]) begin
            rleft[m][i]--;
            if (rleft[m][i] == 0) mring[m][i] = 0;
          end
          if (msnz[m][i]) begin
            sleft[m][i]--;
            if (sleft[m][i] == 0) begin msnz[m][i] = 0; mring[m][i] = 1; rleft[m][i] = AL; end
          end
        end
      end
      if (aok)
        amin[m][alarm_idx] = to_min(m, alarm_time[12:11] * 10 + alarm_time[10:7],
                                    alarm_time[6:4] * 10 + alarm_time[3:0], alarm_pm);
      tod[m] = nt;
    end
  endtask

  function automatic int dut_time(int m);
    return (int'(o_h1[m]) * 10 + int'(o_h2[m])) * 10000 + (int'(o_m1[m]) * 10 + int'(o_m2[m])) * 100
           + int'(o_s1[m]) * 10 + int'(o_s2[m]);
  endfunction

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      int hh, dh, er;
      hh = tod[m] / 3600;
      dh = (m == 0) ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
      er = int'(mring[m][0]) | (int'(mring[m][1]) << 1);
      chk($sformatf("time%0d", m), dut_time(m), dh * 10000 + ((tod[m] / 60) % 60) * 100 + tod[m] % 60);
      chk($sformatf("pm%0d", m), int'(o_pm[m]), (m == 1 && hh >= 12) ? 1 : 0);
      chk($sformatf("tick%0d", m), int'(o_tick[m]), (presc[m] == CD - 1) ? 1 : 0);
      chk($sformatf("set_err%0d", m), int'(o_err[m]), int'(merr[m]));
      chk($sformatf("ring%0d", m), int'(o_ring[m]), er);
      chk($sformatf("led%0d", m), int'(o_led[m]), (er != 0) ? 1 : 0);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_set(logic [19:0] t, bit p);
    set_time = t; set_pm = p; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    $display("set %h pm=%0d -> t24=%0d err24=%0d t12=%0d err12=%0d", t, p, dut_time(0), o_err[0], dut_time(1), o_err[1]);
  endtask

  task automatic do_alarm(int idx, logic [12:0] t, bit p);
    alarm_idx = 3'(idx); alarm_time = t; alarm_pm = p; alarm_wr = 1'b1;
    step();
    alarm_wr = 1'b0;
    $display("alarm_wr idx=%0d %h pm=%0d -> err24=%0d err12=%0d", idx, t, p, o_err[0], o_err[1]);
  endtask

  task automatic run_ticks(int n);
    int c = 0;
    for (int k = 0; k < n * CD * 2 + 8 && c < n; k++) begin
      if (o_tick[0]) c++;
      step();
    end
    chk("ticks_reached", c, n);
  endtask

  task automatic wait_tick_now();
    for (int k = 0; k < 2 * CD + 2 && !o_tick[0]; k++) step();
    chk("tick_seen", int'(o_tick[0]), 1);
  endtask

  task automatic count_ticks_until(int m, int bitn, bit val, output int n);
    n = 0;
    for (int k = 0; k < 400 * CD && o_ring[m][bitn] != val; k++) begin
      if (o_tick[0]) n++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    tv[0] = '{bcd6(2, 4, 0, 0, 0, 0), 0, 1, 1};
    tv[1] = '{bcd6(1, 2, 6, 0, 0, 0), 0, 1, 1};
    tv[2] = '{bcd6(0, 0, 1, 0, 0, 0), 0, 0, 1};
    tv[3] = '{bcd6(1, 3, 0, 0, 0, 0), 0, 0, 1};
    tv[4] = '{bcd6(0, 10, 0, 0, 0, 0), 0, 1, 1};
    tv[5] = '{bcd6(1, 2, 0, 0, 0, 0), 1, 0, 0};
    tv[6] = '{bcd6(2, 3, 5, 9, 5, 9), 0, 0, 1};
    tv[7] = '{bcd6(0, 1, 0, 0, 0, 10), 0, 1, 1};
    tv[8] = '{bcd6(0, 9, 4, 5, 3, 0), 1, 0, 0};

    reset = 1'b1; set_valid = 0; set_time = '0; set_pm = 0; alarm_wr = 0; alarm_idx = '0;
    alarm_time = '0; alarm_pm = 0; alarm_arm = '0; alarm_ack = '0; snooze = '0;
    model_reset();
    #12;
    chk("rst_time24", dut_time(0), 0);
    chk("rst_time12", dut_time(1), 120000);
    chk("rst_pm12", int'(o_pm[1]), 0);
    chk("rst_tick", int'(o_tick[0]), 0);
    chk("rst_ring", int'(o_ring[0]) + int'(o_ring[1]), 0);
    chk("rst_err", int'(o_err[0]) + int'(o_err[1]), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    compare();

    // Free run: one tick per CD cycles.
    n = 0;
    for (int k = 0; k < 240; k++) begin
      if (o_tick[0]) n++;
      step();
    end
    chk("tick_count", n, 60);
    chk("run_time24", dut_time(0), 100);
    chk("run_time12", dut_time(1), 120100);
    $display("free run: %0d ticks t24=%0d t12=%0d", n, dut_time(0), dut_time(1));

    // Rollovers.
    do_set(bcd6(2, 3, 5, 9, 5, 8), 0);
    chk("set2358_err24", int'(o_err[0]), 0);
    chk("set2358_err12", int'(o_err[1]), 1);
    run_ticks(1);
    chk("wrap_a", dut_time(0), 235959);
    run_ticks(1);
    chk("wrap_b", dut_time(0), 0);
    do_set(bcd6(1, 1, 5, 9, 5, 9), 0);
    run_ticks(1);
    chk("noon12", dut_time(1), 120000);
    chk("noon12_pm", int'(o_pm[1]), 1);
    chk("noon24", dut_time(0), 120000);
    do_set(bcd6(1, 2, 5, 9, 5, 9), 1);
    run_ticks(1);
    chk("one12", dut_time(1), 10000);
    chk("one12_pm", int'(o_pm[1]), 1);
    chk("one24", dut_time(0), 130000);

    // Legality table.
    for (int i = 0; i < 9; i++) begin
      do_set(tv[i].t, tv[i].p);
      chk($sformatf("tv%0d_err24", i), int'(o_err[0]), int'(tv[i].e24));
      chk($sformatf("tv%0d_err12", i), int'(o_err[1]), int'(tv[i].e12));
    end
    do_alarm(5, 13'h0082, 0);
    chk("alm_idx5_err24", int'(o_err[0]), 1);
    chk("alm_idx5_err12", int'(o_err[1]), 1);
    do_alarm(1, {2'd0, 4'd0, 3'd3, 4'd0}, 0);
    chk("alm_0030_err24", int'(o_err[0]), 0);
    chk("alm_0030_err12", int'(o_err[1]), 1);
    do_alarm(0, {2'd0, 4'd1, 3'd7, 4'd0}, 0);
    chk("alm_m70_err24", int'(o_err[0]), 1);
    step();
    chk("err_one_cycle", int'(o_err[0]), 0);

    // Two channels ringing together.
    alarm_arm = 2'b11;
    do_alarm(0, {2'd0, 4'd1, 3'd0, 4'd2}, 0);
    do_alarm(1, {2'd0, 4'd1, 3'd0, 4'd2}, 0);
    do_set(bcd6(0, 1, 0, 1, 5, 9), 0);
    run_ticks(1);
    chk("both_ring24", int'(o_ring[0]), 3);
    chk("both_ring12", int'(o_ring[1]), 3);
    chk("led", int'(o_led[0]), 1);
    alarm_ack = 2'b01; step(); alarm_ack = 2'b00;
    chk("ack0_ring", int'(o_ring[0]), 2);
    count_ticks_until(0, 1, 1'b0, n);
    chk("ring1_len", n, AL);
    $display("ring1 self-cleared after %0d ticks", n);

    // Loading HH:MM:00 directly must not fire.
    do_set(bcd6(0, 1, 0, 2, 0, 0), 0);
    run_ticks(1);
    chk("set_on_match", int'(o_ring[0]) + int'(o_ring[1]), 0);

    // Set on a tick cycle wins.
    wait_tick_now();
    do_set(bcd6(0, 5, 3, 0, 0, 0), 0);
    chk("set_vs_tick24", dut_time(0), 53000);
    chk("set_vs_tick12", dut_time(1), 53000);

    // Ack on the match edge.
    do_set(bcd6(0, 1, 0, 1, 5, 9), 0);
    wait_tick_now();
    alarm_ack = 2'b11; step(); alarm_ack = 2'b00;
    chk("ack_vs_match", int'(o_ring[0]) + int'(o_ring[1]), 0);
    chk("ack_vs_match_t", dut_time(0), 10200);

    // Asynchronous reset while ringing.
    do_set(bcd6(0, 1, 0, 1, 5, 9), 0);
    run_ticks(1);
    chk("pre_rst_ring", int'(o_ring[0]), 3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_ring24", int'(o_ring[0]), 0);
    chk("arst_ring12", int'(o_ring[1]), 0);
    chk("arst_led", int'(o_led[0]), 0);
    chk("arst_time24", dut_time(0), 0);
    chk("arst_time12", dut_time(1), 120000);
    @(posedge clk); #1;
    reset = 1'b0;
    compare();
    $display("async reset: ring24=%0d t24=%0d t12=%0d", o_ring[0], dut_time(0), dut_time(1));

    // Snooze.
    do_alarm(0, {2'd0, 4'd1, 3'd0, 4'd2}, 0);
    do_alarm(1, {2'd0, 4'd1, 3'd0, 4'd2}, 0);
    do_set(bcd6(0, 1, 0, 1, 5, 9), 0);
    run_ticks(1);
    snooze = 2'b01; step(); snooze = 2'b00;
`ifdef SNOOZE_EN
    chk("snooze_ring24", int'(o_ring[0]), 2);
    chk("snooze_ring12", int'(o_ring[1]), 2);
    count_ticks_until(0, 0, 1'b1, n);
    chk("snooze_len", n, SM * 60);
    $display("snooze re-ring after %0d ticks", n);
    snooze = 2'b01; step(); snooze = 2'b00;
    run_ticks(5);
    alarm_ack = 2'b01; step(); alarm_ack = 2'b00;
    run_ticks(70);
    chk("snooze_cancel", int'(o_ring[0][0]), 0);
`else
    chk("snooze_ignored", int'(o_ring[0]), 3);
`endif
    alarm_ack = 2'b11; step(); alarm_ack = 2'b00;

    // Randomized traffic near the alarm minutes.
    for (int k = 0; k < 1500; k++) begin
      set_valid = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) set_time = 20'($urandom);
      else set_time = bcd6(0, 1, 0, $urandom_range(1, 3), 5, $urandom_range(0, 9));
      set_pm = ($urandom_range(0, 3) == 0);
      alarm_wr = ($urandom_range(0, 39) == 0);
      alarm_idx = 3'($urandom_range(0, 2));
      alarm_time = ($urandom_range(0, 4) == 0) ? 13'($urandom) : {2'd0, 4'd1, 3'd0, 4'($urandom_range(1, 3))};
      alarm_pm = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) alarm_arm = 2'($urandom);
      else if ($urandom_range(0, 9) == 0) alarm_arm = 2'b11;
      alarm_ack = {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)};
      snooze = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
      step();
    end
    set_valid = 0; alarm_wr = 0; alarm_ack = '0; snooze = '0;
    $display("random phase done: t24=%0d t12=%0d", dut_time(0), dut_time(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
